sseg_scan_driver: RTL and testbench



---
 rtl/sseg_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with double-buffered display data.
// Defining SSEG_LZ_SUPPRESS_EN adds leading-zero suppression.
module sseg_scan_driver #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 50_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_mask,
    output logic [6:0]            sseg,
    output logic [N_DIGITS-1:0]   AN,
    output logic                  DP,
    output logic                  frame_done
);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] shadow_data;
    logic [4*N_DIGITS-1:0] active_data;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [N_DIGITS-1:0]   active_dp;
    logic                  pending;
    logic                  tick;
    logic                  wrap;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_lz;
    logic [N_DIGITS-1:0]   an_lit;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign tick = enable && (div_cnt == DIV_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (tick) begin
                div_cnt <= '0;
                idx     <= wrap ? '0 : idx + 1'b1;
            end else if (enable) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Active buffer only changes on a wrap tick, so a frame is never torn.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            active_data <= '0;
            active_dp   <= '0;
            pending     <= 1'b0;
        end else begin
            if (load) begin
                shadow_data <= data;
                shadow_dp   <= dp_in;
            end
            if (load && wrap) begin
                active_data <= data;
                active_dp   <= dp_in;
                pending     <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end else if (wrap && pending) begin
                active_data <= shadow_data;
                active_dp   <= shadow_dp;
                pending     <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_lit    = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = active_data[4*i +: 4];
                cur_dp    = active_dp[i];
                cur_blank = blank_mask[i];
                an_lit[i] = 1'b0;
            end
        end
    end

`ifdef SSEG_LZ_SUPPRESS_EN
    logic [N_DIGITS-1:0] lz_mask;
    logic                upper_zero;

    // A digit is a leading zero when it and every digit above it hold 0; digit 0 always shows.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (active_data[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end

    always_comb begin
        cur_lz = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) cur_lz = lz_mask[i];
        end
    end
`else
    assign cur_lz = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sseg <= SEG_OFF;
            AN   <= '1;
            DP   <= 1'b1;
        end else if (!enable || cur_blank) begin
            sseg <= SEG_OFF;
            AN   <= '1;
            DP   <= 1'b1;
        end else if (cur_lz) begin
            sseg <= SEG_OFF;
            AN   <= cur_dp ? an_lit : '1;
            DP   <= ~cur_dp;
        end else begin
            sseg <= hex7(cur_nib);
            AN   <= an_lit;
            DP   <= ~cur_dp;
        end
    end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (4 digits, 4 clocks per slot).
// Directed tables and sequences plus random stimulus against a counting reference model.
module tb_sseg_scan_driver;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [6:0]  sseg;
    logic [3:0]  AN;
    logic        DP;
    logic        frame_done;

    sseg_scan_driver #(.N_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load), .data(data),
        .dp_in(dp_in), .blank_mask(blank_mask), .sseg(sseg), .AN(AN), .DP(DP),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } hex_vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } scan_vec_t;

    hex_vec_t  hex_vecs[16];
    scan_vec_t scan_vecs[4];

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: enabled-cycle count since reset plus the two display buffers.
    int          m_cnt = 0;
    logic [15:0] m_shadow = 16'h0;
    logic [15:0] m_active = 16'h0;
    logic [3:0]  m_dp_sh = 4'h0;
    logic [3:0]  m_dp_act = 4'h0;
    bit          m_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input bit en, input bit ld, input logic [15:0] d,
                        input logic [3:0] dp, input logic [3:0] bm);
        int         di;
        bit         wrap;
        bit         sup;
        logic [3:0] nib;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        @(negedge clk);
        enable = en;
        load = ld;
        data = d;
        dp_in = dp;
        blank_mask = bm;
        di = (m_cnt / RD) % ND;
        wrap = en && ((m_cnt % FRAME) == FRAME - 1);
        nib = m_active[4*di +: 4];
        sup = 1'b0;
`ifdef SSEG_LZ_SUPPRESS_EN
        sup = (di != 0) && ((m_active >> (4*di)) == 16'h0);
`endif
        an_e = 4'hF;
        seg_e = 7'h7F;
        dp_e = 1'b1;
        if (en && !bm[di]) begin
            if (!sup) begin
                an_e = ~(4'b0001 << di);
                seg_e = hex_vecs[nib].seg;
                dp_e = ~m_dp_act[di];
            end else if (m_dp_act[di]) begin
                an_e = ~(4'b0001 << di);
                dp_e = 1'b0;
            end
        end
        if (ld) begin
            m_shadow = d;
            m_dp_sh = dp;
        end
        if (ld && wrap) begin
            m_active = d;
            m_dp_act = dp;
            m_pend = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
        end else if (wrap && m_pend) begin
            m_active = m_shadow;
            m_dp_act = m_dp_sh;
            m_pend = 1'b0;
        end
        if (en) m_cnt++;
        @(posedge clk);
        #1;
        check("scan_model", {19'h0, frame_done, DP, AN, sseg}, {19'h0, wrap, dp_e, an_e, seg_e});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic to_frame_start();
        idle((FRAME - (m_cnt % FRAME)) % FRAME);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] dpv;
        logic       exp_dp;

        hex_vecs[0]  = '{4'h0, 7'b1000000};
        hex_vecs[1]  = '{4'h1, 7'b1111001};
        hex_vecs[2]  = '{4'h2, 7'b0100100};
        hex_vecs[3]  = '{4'h3, 7'b0110000};
        hex_vecs[4]  = '{4'h4, 7'b0011001};
        hex_vecs[5]  = '{4'h5, 7'b0010010};
        hex_vecs[6]  = '{4'h6, 7'b0000010};
        hex_vecs[7]  = '{4'h7, 7'b1111000};
        hex_vecs[8]  = '{4'h8, 7'b0000000};
        hex_vecs[9]  = '{4'h9, 7'b0010000};
        hex_vecs[10] = '{4'hA, 7'b0001000};
        hex_vecs[11] = '{4'hB, 7'b0000011};
        hex_vecs[12] = '{4'hC, 7'b1000110};
        hex_vecs[13] = '{4'hD, 7'b0100001};
        hex_vecs[14] = '{4'hE, 7'b0000110};
        hex_vecs[15] = '{4'hF, 7'b0001110};
        scan_vecs[0] = '{4'b1110, 7'b0011001};
        scan_vecs[1] = '{4'b1101, 7'b0110000};
        scan_vecs[2] = '{4'b1011, 7'b0100100};
        scan_vecs[3] = '{4'b0111, 7'b1111001};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_an", AN, 4'b1111);
        check("reset_sseg", sseg, 7'h7F);
        check("reset_dp", DP, 1'b1);
        check("reset_frame_done", frame_done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Scan of 1234 after the first wrap
        step(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
        idle(15);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            check("scan_an", AN, scan_vecs[k/RD].an);
            check("scan_sseg", sseg, scan_vecs[k/RD].seg);
            check("scan_frame_done", frame_done, (k == FRAME - 1) ? 1'b1 : 1'b0);
        end

        // Mid-frame load takes effect only after the wrap
        idle(4);
        step(1'b1, 1'b1, 16'hABCD, 4'h0, 4'h0);
        idle(11);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        check("midload_an", AN, 4'b1110);
        check("midload_sseg", sseg, 7'b0100001);

        // Load exactly on the wrap tick goes straight to the active buffer
        idle(14);
        step(1'b1, 1'b1, 16'h0F00, 4'h0, 4'h0);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            if (k % RD == 0 && k / RD < 3) begin
                check("wrapload_an", AN, scan_vecs[k/RD].an);
                check("wrapload_sseg", sseg, (k / RD == 2) ? 7'b0001110 : 7'b1000000);
            end
        end

        // Back-to-back loads: last one wins
        idle(2);
        step(1'b1, 1'b1, 16'h1111, 4'h0, 4'h0);
        step(1'b1, 1'b1, 16'h2222, 4'h0, 4'h0);
        idle(12);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            if (k % RD == 0) begin
                check("b2b_an", AN, scan_vecs[k/RD].an);
                check("b2b_sseg", sseg, 7'b0100100);
            end
        end

        // Freeze at digit 2, then resume there
        idle(8);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
            check("freeze_an", AN, 4'b1111);
            check("freeze_frame_done", frame_done, 1'b0);
        end
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        check("resume_an", AN, 4'b1011);

        // Live blank mask on digit 2
        idle(6);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'b0100);
            check("mask_an2", AN[2], 1'b1);
            if (k / RD == 2) check("mask_sseg", sseg, 7'h7F);
        end

        // Hex decode table, alternating decimal point on digit 0
        for (int v = 0; v < 16; v++) begin
            dpv = {3'b000, v[0]};
            exp_dp = ~dpv[0];
            step(1'b1, 1'b1, {4{hex_vecs[v].nib}}, dpv, 4'h0);
            to_frame_start();
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            check("hex_sseg", sseg, hex_vecs[v].seg);
            check("hex_dp", DP, exp_dp);
        end

`ifdef SSEG_LZ_SUPPRESS_EN
        // Leading zeros of 0070 are dark; a lit decimal point keeps its digit selected
        step(1'b1, 1'b1, 16'h0070, 4'h0, 4'h0);
        to_frame_start();
        for (int k = 0; k < FRAME; k++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            if (k == 0) check("lz_d0_sseg", sseg, 7'b1000000);
            if (k == 4) check("lz_d1_sseg", sseg, 7'b1111000);
            if (k == 12) check("lz_d3_an", AN, 4'b1111);
            if (k == 12) check("lz_d3_sseg", sseg, 7'h7F);
        end
        step(1'b1, 1'b1, 16'h0070, 4'b1000, 4'h0);
        to_frame_start();
        idle(12);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        check("lz_dp_an", AN, 4'b0111);
        check("lz_dp_sseg", sseg, 7'h7F);
        check("lz_dp_dp", DP, 1'b0);
`endif

        // Random traffic against the model
        for (int r = 0; r < 1500; r++) begin
            step(($urandom_range(9) != 0), ($urandom_range(7) == 0), 16'($urandom),
                 4'($urandom), ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0);
        end

        // Asynchronous reset mid-slot
        step(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
        idle(2 * FRAME);
        check("pre_reset_lit", (AN == 4'b1111), 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_an", AN, 4'b1111);
        check("async_sseg", sseg, 7'h7F);
        check("async_dp", DP, 1'b1);
        check("async_frame_done", frame_done, 1'b0);
        #1;
        reset_n = 1'b1;
        m_cnt = 0;
        m_shadow = 16'h0;
        m_active = 16'h0;
        m_dp_sh = 4'h0;
        m_dp_act = 4'h0;
        m_pend = 1'b0;
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
